conv1d_cmd_driver: RTL and testbench



---
 rtl/conv1d_cmd_driver.sv | 160 ++++++++++++++++
 tb/tb_conv1d_cmd_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_cmd_driver.sv
// Hardware initiator for the conv1d CFU command bus: forwards WRITE commands and runs
// set_x/start/poll/read sequences. Optional poll timeout: define CONV1D_DRV_TIMEOUT_EN.
module conv1d_cmd_driver #(
    parameter int INT32_SIZE     = 32,
    parameter int NOP_CMD        = 16,
    parameter int POLL_GAP       = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [6:0]            req_cmd,
    input  logic [INT32_SIZE-1:0] req_addr,
    input  logic [INT32_SIZE-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [INT32_SIZE-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  acc_en,
    output logic [6:0]            acc_cmd,
    output logic [INT32_SIZE-1:0] acc_inp0,
    output logic [INT32_SIZE-1:0] acc_inp1,
    input  logic [INT32_SIZE-1:0] acc_ret
);
    // state names the command currently on the accelerator bus
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WRITE      = 4'd1;
    localparam logic [3:0] S_SET_X      = 4'd2;
    localparam logic [3:0] S_START      = 4'd3;
    localparam logic [3:0] S_POLL_ISSUE = 4'd4;
    localparam logic [3:0] S_POLL_WAIT  = 4'd5;
    localparam logic [3:0] S_POLL_GAP   = 4'd6;
    localparam logic [3:0] S_READ_ISSUE = 4'd7;
    localparam logic [3:0] S_READ_WAIT  = 4'd8;
    localparam logic [3:0] S_RESP       = 4'd9;

    localparam logic [6:0] NOP       = 7'(NOP_CMD);
    localparam logic [6:0] CMD_SET_X = 7'd8;
    localparam logic [6:0] CMD_START = 7'd6;
    localparam logic [6:0] CMD_POLL  = 7'd9;
    localparam logic [6:0] CMD_READ  = 7'd7;
    localparam logic [7:0] GAP_LAST  = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

    if (POLL_GAP < 0 || POLL_GAP > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("conv1d_cmd_driver: POLL_GAP must be 0..255 and TIMEOUT_CYCLES >= 1");
    end

    logic [3:0] state, nxt;
    logic [7:0] gap_cnt;
    logic       polling, done, reserved, timed_out;

    assign polling   = (state == S_POLL_ISSUE) || (state == S_POLL_WAIT) || (state == S_POLL_GAP);
    assign done      = (state == S_POLL_WAIT) && acc_ret[0];
    assign reserved  = (req_cmd == CMD_START) || (req_cmd == CMD_READ) || (req_cmd == CMD_POLL);
    assign req_ready = (state == S_IDLE) && !rst;

`ifdef CONV1D_DRV_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt;

    // the budget covers every cycle spent polling, gap cycles included
    assign timed_out = polling && !done && (tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            rsp_error <= 1'b0;
        end else begin
            if (state == S_START)
                tmo_cnt <= '0;
            else if (polling)
                tmo_cnt <= tmo_cnt + 32'd1;
            if (timed_out)
                rsp_error <= 1'b1;
            else if (state == S_READ_WAIT || (state == S_RESP && rsp_ready))
                rsp_error <= 1'b0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:       if (req_valid) nxt = req_op ? S_SET_X : S_WRITE;
            S_WRITE:      nxt = S_IDLE;
            S_SET_X:      nxt = S_START;
            S_START:      nxt = S_POLL_ISSUE;
            S_POLL_ISSUE: nxt = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (done)
                    nxt = S_READ_ISSUE;
                else if (POLL_GAP == 0)
                    nxt = S_POLL_ISSUE;
                else
                    nxt = S_POLL_GAP;
            end
            S_POLL_GAP:   if (gap_cnt == GAP_LAST) nxt = S_POLL_ISSUE;
            S_READ_ISSUE: nxt = S_READ_WAIT;
            S_READ_WAIT:  nxt = S_RESP;
            S_RESP:       if (rsp_ready) nxt = S_IDLE;
            default:      nxt = S_IDLE;
        endcase
        if (timed_out)
            nxt = S_RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            acc_en    <= 1'b1;
            acc_cmd   <= NOP;
            acc_inp0  <= '0;
            acc_inp1  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state   <= nxt;
            gap_cnt <= (state == S_POLL_GAP) ? gap_cnt + 8'd1 : 8'd0;
            acc_en  <= 1'b1;

            // commands are decoded from the next state so each lasts exactly one cycle
            acc_cmd  <= NOP;
            acc_inp0 <= '0;
            acc_inp1 <= '0;
            case (nxt)
                S_WRITE: begin
                    if (!reserved) begin
                        acc_cmd  <= req_cmd;
                        acc_inp0 <= req_addr;
                        acc_inp1 <= req_data;
                    end
                end
                S_SET_X: begin
                    acc_cmd  <= CMD_SET_X;
                    acc_inp1 <= req_data;
                end
                S_START:      acc_cmd <= CMD_START;
                S_POLL_ISSUE: acc_cmd <= CMD_POLL;
                S_READ_ISSUE: acc_cmd <= CMD_READ;
                default: ;
            endcase

            if (state == S_READ_WAIT) begin
                rsp_valid <= 1'b1;
                rsp_data  <= acc_ret;
            end else if (timed_out) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
            end else if (state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv1d_cmd_driver.sv
// Bench for conv1d_cmd_driver: behavioural accelerator model, vector table, random traffic
// and hand-written stall/reset/timeout sequences; expected cycle positions come from arithmetic.
module tb_conv1d_cmd_driver;
    localparam int G   = 2;
    localparam int T   = 64;
    localparam logic [6:0] NOP = 7'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_op;
    logic [6:0]  req_cmd;
    logic [31:0] req_addr, req_data;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_data;
    logic        acc_en;
    logic [6:0]  acc_cmd;
    logic [31:0] acc_inp0, acc_inp1;
    logic [31:0] acc_ret = '0;

    conv1d_cmd_driver #(.INT32_SIZE(32), .NOP_CMD(16), .POLL_GAP(G), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .acc_en(acc_en), .acc_cmd(acc_cmd), .acc_inp0(acc_inp0), .acc_inp1(acc_inp1),
        .acc_ret(acc_ret)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // accelerator: done is reported on the done_poll-th status read after start (0 = never)
    int          done_poll = 0;
    logic [31:0] ret_val   = '0;
    int          polls     = 0;
    always @(posedge clk) begin
        if (acc_en) begin
            case (acc_cmd)
                7'd6: begin polls <= 0; acc_ret <= '0; end
                7'd9: begin
                    polls   <= polls + 1;
                    acc_ret <= {31'd0, (done_poll != 0 && polls + 1 >= done_poll)};
                end
                7'd7:    acc_ret <= ret_val;
                default: acc_ret <= '0;
            endcase
        end
    end

    typedef struct {
        int          cyc;
        logic [6:0]  cmd;
        logic [31:0] i0;
        logic [31:0] i1;
    } tr_t;
    tr_t trace[$];
    int  en_low = 0;

    always @(negedge clk) begin
        if (acc_en !== 1'b1) en_low++;
        if (!rst && acc_cmd != NOP) trace.push_back(tr_t'{cyc, acc_cmd, acc_inp0, acc_inp1});
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // present a request from a negedge; returns at the negedge after the accepting edge
    task automatic offer(input logic op, input logic [6:0] c, input logic [31:0] ad,
                         input logic [31:0] dt, output int a);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_cmd = c; req_addr = ad; req_data = dt;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("req_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        a = cyc;
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] c, input logic [31:0] ad, input logic [31:0] dt,
                            input logic [6:0] exp_cmd);
        int a;
        trace.delete();
        offer(1'b0, c, ad, dt, a);
        chk("wr_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("wr_ready_back", 32'(req_ready), 32'd1);
        chk("wr_trace_len", 32'(trace.size()), (exp_cmd == NOP) ? 32'd0 : 32'd1);
        if (exp_cmd != NOP && trace.size() >= 1) begin
            chk("wr_cycle", 32'(trace[0].cyc), 32'(a));
            chk("wr_cmd", 32'(trace[0].cmd), 32'(exp_cmd));
            chk("wr_inp0", trace[0].i0, ad);
            chk("wr_inp1", trace[0].i1, dt);
        end
    endtask

    task automatic do_run(input logic [31:0] x, input int dp, input logic [31:0] rv,
                          input int stall, input logic [31:0] exp_rsp);
        int a, n, r, rsp_at, c7;
        tr_t exp_q[$];
        trace.delete();
        done_poll = dp;
        ret_val   = rv;
        rsp_ready = (stall == 0);
        offer(1'b1, 7'd0, 32'd0, x, a);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk("run_rsp_seen", 32'(rsp_valid), 32'd1);
        r = cyc;

        exp_q.push_back(tr_t'{a, 7'd8, 32'd0, x});
        exp_q.push_back(tr_t'{a + 1, 7'd6, 32'd0, 32'd0});
        if (dp == 0) begin
            for (int k = 0; k * (2 + G) < T; k++)
                exp_q.push_back(tr_t'{a + 2 + k * (2 + G), 7'd9, 32'd0, 32'd0});
            rsp_at = a + 2 + T;
        end else begin
            for (int k = 0; k < dp; k++)
                exp_q.push_back(tr_t'{a + 2 + k * (2 + G), 7'd9, 32'd0, 32'd0});
            c7 = a + 2 + (dp - 1) * (2 + G) + 2;
            exp_q.push_back(tr_t'{c7, 7'd7, 32'd0, 32'd0});
            rsp_at = c7 + 2;
        end
        chk("run_latency", 32'(r - a), 32'(rsp_at - a));
        chk("run_rsp_data", rsp_data, exp_rsp);
        chk("run_rsp_error", 32'(rsp_error), (dp == 0) ? 32'd1 : 32'd0);
        chk("run_trace_len", 32'(trace.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++) begin
            chk("run_trace_cyc", 32'(trace[i].cyc), 32'(exp_q[i].cyc));
            chk("run_trace_cmd", 32'(trace[i].cmd), 32'(exp_q[i].cmd));
            if (exp_q[i].cmd == 7'd8) chk("run_start_x", trace[i].i1, x);
        end

        if (stall > 0) begin
            req_valid = 1'b1; req_op = 1'b1; req_data = 32'd7;
            for (int i = 0; i < stall; i++) begin
                chk("stall_req_ready", 32'(req_ready), 32'd0);
                chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("stall_rsp_data", rsp_data, exp_rsp);
                @(negedge clk);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("rsp_handshake_clear", 32'(rsp_valid), 32'd0);
        chk("idle_after_rsp", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        op;
        logic [6:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        int          dpoll;
        logic [31:0] retv;
        logic [6:0]  exp_cmd;
        logic [31:0] exp_rsp;
    } vec_t;

    initial begin
        vec_t vecs[10];
        int a, cnt;
        logic [6:0]  c;
        logic [31:0] rv;

        vecs[0] = '{1'b0, 7'd2,   32'd8,  32'h0403_0201, 0, 32'd0, 7'd2,   32'd0};
        vecs[1] = '{1'b0, 7'd6,   32'd1,  32'h1111_1111, 0, 32'd0, NOP,    32'd0};
        vecs[2] = '{1'b0, 7'd7,   32'd2,  32'h2222_2222, 0, 32'd0, NOP,    32'd0};
        vecs[3] = '{1'b0, 7'd9,   32'd3,  32'h3333_3333, 0, 32'd0, NOP,    32'd0};
        vecs[4] = '{1'b0, 7'd8,   32'd4,  32'h0000_0005, 0, 32'd0, 7'd8,   32'd0};
        vecs[5] = '{1'b0, 7'd0,   32'hFF, 32'hFFFF_FFFF, 0, 32'd0, 7'd0,   32'd0};
        vecs[6] = '{1'b0, 7'd127, 32'd5,  32'h8000_0000, 0, 32'd0, 7'd127, 32'd0};
        vecs[7] = '{1'b1, 7'd0,   32'd0,  32'd3,         1, 32'h7F, 7'd0,  32'h7F};
        vecs[8] = '{1'b1, 7'd0,   32'd0,  32'd5,         4, 32'hDEAD_BEEF, 7'd0, 32'hDEAD_BEEF};
        vecs[9] = '{1'b1, 7'd0,   32'd0,  32'd0,         2, 32'd0, 7'd0,   32'd0};

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_cmd = '0;
        req_addr = '0; req_data = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_acc_cmd", 32'(acc_cmd), 32'(NOP));
        chk("rst_acc_inp0", acc_inp0, 32'd0);
        chk("rst_acc_inp1", acc_inp1, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_acc_cmd", 32'(acc_cmd), 32'(NOP));
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].op == 1'b0)
                do_write(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].exp_cmd);
            else
                do_run(vecs[i].data, vecs[i].dpoll, vecs[i].retv, 0, vecs[i].exp_rsp);
        end

        do_run(32'd11, 2, 32'h1234_5678, 5, 32'h1234_5678);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                c = 7'($urandom_range(0, 127));
                do_write(c, $urandom, $urandom,
                         (c == 7'd6 || c == 7'd7 || c == 7'd9) ? NOP : c);
            end else begin
                rv = $urandom;
                do_run($urandom, int'($urandom_range(1, 5)), rv, 0, rv);
            end
        end

`ifdef CONV1D_DRV_TIMEOUT_EN
        do_run(32'd9, 0, 32'hFFFF_FFFF, 0, 32'd0);
`endif

        // reset in the middle of polling: no response may ever appear
        trace.delete();
        done_poll = 0;
        offer(1'b1, 7'd0, 32'd0, 32'd4, a);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_acc_cmd", 32'(acc_cmd), 32'(NOP));
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        trace.delete();
        @(negedge clk);
        chk("midrst_idle", 32'(req_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (rsp_valid === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("midrst_no_rsp", 32'(cnt), 32'd0);
        chk("midrst_no_cmds", 32'(trace.size()), 32'd0);

        do_run(32'd1, 3, 32'h0000_00AB, 0, 32'h0000_00AB);
        chk("acc_en_always_high", 32'(en_low), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end
endmodule
